tone_arbiter: RTL and testbench
===============================

# tone_arbiter

Shares the single piezo `tone_generator` among several tone sources: music streamer, button key-click, alarm/metronome. Sits between the sources and `tone_generator`. Grants the speaker to one requester at a time by fixed priority, with a minimum ownership time and a silent gap between owners. Drives the generator's `tone_switch_period` and `output_enable` inputs.

## Interface
- `NUM_REQ`, 3: number of requesters; must be 2..8.
- `PERIOD_WIDTH`, 24: width of each tone period; matches `tone_generator`.
- `MIN_HOLD_CYCLES`, 33_000: minimum cycles an owner keeps the grant before preemption (1 ms at 33 MHz); must be ≥1.
- `GAP_CYCLES`, 330: silent cycles inserted between owners; must be ≥1.

- `clk`  in  1  system clock (`CLK_33MHZ_FPGA`).
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  request per source; bit 0 = highest priority.
- `req_period`  in  NUM_REQ*PERIOD_WIDTH  per-source period; source i in bits [i*PERIOD_WIDTH +: PERIOD_WIDTH].
- `grant`  out  NUM_REQ  one-hot or zero; current owner.
- `owner_id`  out  3  index of the current owner; 0 when no grant.
- `tone_switch_period`  out  PERIOD_WIDTH  to `tone_generator`.
- `output_enable`  out  1  to `tone_generator`.

## Operation
- States:
  - IDLE: no owner, speaker silent.
  - OWN: one requester granted.
  - GAP: speaker silent between owners.
- Winner: lowest-index asserted `req` bit.
- IDLE:
  - Any `req` set: go to OWN with the winner; clear `hold_cnt`.
  - Otherwise stay in IDLE.
- OWN:
  - `hold_cnt` increments each cycle and saturates at MIN_HOLD_CYCLES-1.
  - Release: `req[owner]`=0 → GAP. Allowed at any time, regardless of `hold_cnt`.
  - Preemption: a lower-index `req` is set and `hold_cnt` = MIN_HOLD_CYCLES-1 → GAP.
  - Higher-index (lower priority) requests never preempt.
  - Release takes precedence when release and preemption occur in the same cycle (same next state).
- GAP:
  - `gap_cnt` counts GAP_CYCLES cycles.
  - On the last gap cycle, arbitrate as in IDLE using `req` sampled that cycle.
  - Winner found → OWN. Otherwise → IDLE.
  - The previous owner may win again if it is still the highest-priority request.
- Outputs in OWN:
  - `grant` = one-hot(owner); `owner_id` = owner.
  - `output_enable` = 1.
  - `tone_switch_period` = `req_period` slice of the owner. It tracks changes live, with 1-cycle register latency, so the streamer can change notes without re-arbitrating.
- Outputs in IDLE and GAP: `grant`=0, `owner_id`=0, `output_enable`=0, `tone_switch_period`=0.
- Counter widths: `$clog2` of the respective maximum, minimum 1 bit. Neither counter ever wraps.

## Timing
- All outputs are registered and reset asynchronously to 0. State resets to IDLE; `hold_cnt` and `gap_cnt` reset to 0.
- Grant latency: `req` rises in cycle t while in IDLE → `grant`, `output_enable` and period valid at t+1.
- Release: `req[owner]` falls in cycle t → outputs 0 from t+1.
  - Cycles t+1..t+GAP_CYCLES are GAP.
  - The earliest next grant is at t+GAP_CYCLES+1.
- Preemption: the higher-priority request has been pending since grant at cycle g → the owner keeps the grant through g+MIN_HOLD_CYCLES-1. Outputs drop at g+MIN_HOLD_CYCLES; the new grant follows GAP_CYCLES later.
- Period change by the owner in cycle t → appears on `tone_switch_period` at t+1.
- `rst` asserted mid-OWN or mid-GAP: outputs are 0 immediately (asynchronous). The first grant after release is at the first clock edge with `rst` low and `req` set, plus 1 cycle.

## Test plan
Parameters for all scenarios: NUM_REQ=3, MIN_HOLD_CYCLES=8, GAP_CYCLES=2.

- Single request, grant and period tracking:
  - Stimulus: `req`=3'b100 with period 1000, then period changed to 2000 while held.
  - Required: `grant`=3'b100, `owner_id`=2, `output_enable`=1 one cycle after `req`; period 1000, then 2000 exactly 1 cycle after the change.
- Release and gap:
  - Stimulus: owner 2 drops `req` at cycle t while `req[1]` is held.
  - Required: outputs 0 at t+1 and t+2; `grant`=3'b010 at t+3.
- Preemption with minimum hold:
  - Stimulus: owner 2 granted at g; `req[0]` rises at g+1.
  - Required: `grant`=3'b100 through g+7; 0 at g+8 and g+9; 3'b001 at g+10.
- No lower-priority preemption:
  - Stimulus: owner 0 held for 50 cycles with `req[2]` asserted throughout.
  - Required: `grant` stays 3'b001 all 50 cycles.
- Simultaneous requests from IDLE:
  - Stimulus: `req`=3'b111 in one cycle.
  - Required: `grant`=3'b001 next cycle.
- Reset mid-operation:
  - Stimulus: `rst` pulsed asynchronously between clock edges during OWN, then again during GAP.
  - Required: all outputs 0 before the next edge; re-grant 1 cycle after the first edge with `rst` low.

Source files
------------

// File: rtl/tone_arbiter.sv
// tone_arbiter: shares one piezo tone_generator among several tone sources.
// Fixed priority (bit 0 highest), a minimum ownership time before a
// higher-priority source may preempt, and a silent gap between owners.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous, active-high reset
//   req                 per-source request, bit 0 = highest priority
//   req_period          per-source tone period, source i at [i*PERIOD_WIDTH +: PERIOD_WIDTH]
//   grant               one-hot current owner, zero when nobody owns the speaker
//   owner_id            index of the current owner, 0 when no grant
//   tone_switch_period  period forwarded to tone_generator (0 when silent)
//   output_enable       speaker enable forwarded to tone_generator
module tone_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned PERIOD_WIDTH    = 24,
  parameter int unsigned MIN_HOLD_CYCLES = 33_000,
  parameter int unsigned GAP_CYCLES      = 330
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PERIOD_WIDTH-1:0] req_period,
  output logic [NUM_REQ-1:0]              grant,
  output logic [2:0]                      owner_id,
  output logic [PERIOD_WIDTH-1:0]         tone_switch_period,
  output logic                            output_enable
);

  localparam int unsigned OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W   = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned HOLD_MAX = MIN_HOLD_CYCLES - 1;
  localparam int unsigned GAP_LAST = GAP_CYCLES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [OWNER_W-1:0]   owner, owner_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;

  logic [NUM_REQ-1:0]      grant_nxt;
  logic [2:0]              owner_id_nxt;
  logic [PERIOD_WIDTH-1:0] period_nxt;
  logic                    enable_nxt;

  logic [PERIOD_WIDTH-1:0] period_arr [NUM_REQ];
  logic                    win_found;
  logic [OWNER_W-1:0]      win_idx;
  logic                    higher_pending;
  logic                    hold_done;
  logic                    gap_done;

  // Unpack the flat period bus into one entry per source.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      period_arr[i] = req_period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
    end
  end

  // Priority encoder: scanning downward lets the lowest asserted index win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = OWNER_W'(i);
      end
    end
  end

  // Any request with strictly higher priority than the current owner.
  always_comb begin
    higher_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (i < int'(owner))) begin
        higher_pending = 1'b1;
      end
    end
  end

  assign hold_done = (hold_cnt == HOLD_W'(HOLD_MAX));
  assign gap_done  = (gap_cnt == GAP_W'(GAP_LAST));

  // Next state, counters and next registered outputs.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    hold_nxt     = hold_cnt;
    gap_nxt      = gap_cnt;
    grant_nxt    = '0;
    owner_id_nxt = '0;
    period_nxt   = '0;
    enable_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = OWN;
          owner_nxt = win_idx;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        // Release is checked first so it wins over a simultaneous preemption.
        if (!req[owner]) begin
          state_nxt = GAP;
          gap_nxt   = '0;
        end else if (higher_pending && hold_done) begin
          state_nxt = GAP;
          gap_nxt   = '0;
        end else if (!hold_done) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_done) begin
          if (win_found) begin
            state_nxt = OWN;
            owner_nxt = win_idx;
            hold_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they register with it;
    // the period follows the owner's slice live.
    if (state_nxt == OWN) begin
      grant_nxt    = NUM_REQ'(1) << owner_nxt;
      owner_id_nxt = 3'(owner_nxt);
      period_nxt   = period_arr[owner_nxt];
      enable_nxt   = 1'b1;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      owner              <= '0;
      hold_cnt           <= '0;
      gap_cnt            <= '0;
      grant              <= '0;
      owner_id           <= '0;
      tone_switch_period <= '0;
      output_enable      <= 1'b0;
    end else begin
      state              <= state_nxt;
      owner              <= owner_nxt;
      hold_cnt           <= hold_nxt;
      gap_cnt            <= gap_nxt;
      grant              <= grant_nxt;
      owner_id           <= owner_id_nxt;
      tone_switch_period <= period_nxt;
      output_enable      <= enable_nxt;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter with NUM_REQ=3, MIN_HOLD_CYCLES=8, GAP_CYCLES=2.
// A cycle table of {req, periods, expected outputs}; expectations are queued
// when a vector is driven and popped when the outputs are sampled after the edge.
module tb_tone_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned PW = 24;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*PW-1:0] req_period;
  logic [NR-1:0]   grant;
  logic [2:0]      owner_id;
  logic [PW-1:0]   tone_switch_period;
  logic            output_enable;

  tone_arbiter #(
    .NUM_REQ(NR),
    .PERIOD_WIDTH(PW),
    .MIN_HOLD_CYCLES(8),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_period(req_period),
    .grant(grant),
    .owner_id(owner_id),
    .tone_switch_period(tone_switch_period),
    .output_enable(output_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] p0, p1, p2;
    logic [2:0]  grant;
    logic [2:0]  id;
    logic        oe;
    logic [23:0] per;
  } vec_t;

  typedef struct {
    logic [2:0]  grant;
    logic [2:0]  id;
    logic        oe;
    logic [23:0] per;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic [2:0] r, input logic [23:0] a, input logic [23:0] b,
                              input logic [23:0] c, input logic [2:0] g, input logic [2:0] id,
                              input logic oe, input logic [23:0] per);
    vec_t v;
    v.req = r; v.p0 = a; v.p1 = b; v.p2 = c;
    v.grant = g; v.id = id; v.oe = oe; v.per = per;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input exp_t e);
    checks++;
    if (grant !== e.grant || owner_id !== e.id || output_enable !== e.oe ||
        tone_switch_period !== e.per) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d oe=%b per=%0d, want grant=%b id=%0d oe=%b per=%0d",
               name, grant, owner_id, output_enable, tone_switch_period,
               e.grant, e.id, e.oe, e.per);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] g, input logic [2:0] id, input logic oe,
                              input logic [23:0] per);
    exp_t e;
    e.grant = g; e.id = id; e.oe = oe; e.per = per;
    return e;
  endfunction

  task automatic apply(input int idx);
    vec_t v;
    exp_t e;
    v = vecs[idx];
    @(negedge clk);
    req        = v.req;
    req_period = {v.p2, v.p1, v.p0};
    sb.push_back(mk(v.grant, v.id, v.oe, v.per));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL vec%0d: scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d", idx), e);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_period = '0;

    // Single request, grant and live period tracking.
    add(3'b100, 300, 500, 1000, 3'b100, 2, 1, 1000);
    add(3'b100, 300, 500, 1000, 3'b100, 2, 1, 1000);
    add(3'b100, 300, 500, 2000, 3'b100, 2, 1, 2000);
    add(3'b100, 300, 500, 2000, 3'b100, 2, 1, 2000);
    // Release by owner 2 before hold expires, req[1] waiting: two gap cycles.
    add(3'b010, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b010, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b010, 300, 500, 2000, 3'b010, 1, 1, 500);
    // Owner 1 releases, owner 2 requests during gap and wins at its end.
    add(3'b000, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b100, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b100, 300, 500, 2000, 3'b100, 2, 1, 2000);
    // req[0] pending from g+1: owner 2 holds through g+7, gap, then owner 0.
    for (int k = 0; k < 7; k++) add(3'b101, 300, 500, 2000, 3'b100, 2, 1, 2000);
    add(3'b101, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b101, 300, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b101, 300, 500, 2000, 3'b001, 0, 1, 300);
    // Lower-priority req[2] never preempts owner 0; period change mid-hold.
    for (int k = 0; k < 50; k++) begin
      if (k < 25) add(3'b101, 300, 500, 2000, 3'b001, 0, 1, 300);
      else        add(3'b101, 350, 500, 2000, 3'b001, 0, 1, 350);
    end
    // Release, gap with no requester falls back to IDLE, then all request.
    add(3'b000, 350, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b000, 350, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b000, 350, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b000, 350, 500, 2000, 3'b000, 0, 0, 0);
    add(3'b111, 350, 500, 2000, 3'b001, 0, 1, 350);
    add(3'b111, 350, 500, 2000, 3'b001, 0, 1, 350);

    #3;
    check("reset_state", mk(3'b000, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // Asynchronous reset during OWN: outputs clear before the next edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_own_zero", mk(3'b000, 0, 0, 0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("rst_own_regrant", mk(3'b001, 0, 1, 350));

    // Asynchronous reset during GAP: next edge grants directly from IDLE.
    @(negedge clk);
    req = 3'b000;
    @(posedge clk);
    #1 check("gap_entry", mk(3'b000, 0, 0, 0));
    #1 rst = 1'b1;
    req = 3'b010;
    #1 check("rst_gap_zero", mk(3'b000, 0, 0, 0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("rst_gap_regrant", mk(3'b010, 1, 1, 500));

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
